// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 constants and round/pack state encoding
package fp32_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam int SIG_W   = 24;
    localparam int FRAC_W  = 23;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        DENORM,
        ROUND,
        PACK
    } state_t;

endpackage

// File: rtl/fp32_rne_round.sv
// rtl/fp32_rne_round.sv - combinational round-to-nearest-even increment on a 24-bit significand
module fp32_rne_round
    import fp32_pkg::*;
(
    input  logic [SIG_W-1:0] s,
    input  logic             g,
    input  logic             S,
    output logic [SIG_W:0]   r,
    output logic             inexact
);

    logic inc;

    // Ties (g set, nothing below) only round up when the kept LSB is odd.
    assign inc     = g & (S | s[0]);
    assign r       = {1'b0, s} + {{SIG_W{1'b0}}, inc};
    assign inexact = g | S;

endmodule

// File: rtl/fp32_round_pack.sv
// rtl/fp32_round_pack.sv - FP32 multiplier normalise/round/pack stage, one shift per cycle
// Optional flush-to-zero of tiny results when FP32_FTZ_EN is defined.
module fp32_round_pack
    import fp32_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [MANT_W-1:0] mant_i,
    input  logic              nan_i,
    input  logic              inf_i,
    input  logic              zero_i,
    output logic [31:0]       product_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              inexact_o
);

    localparam int HID     = MANT_W - 2;
    localparam int GRD     = HID - SIG_W;
    localparam int DEN_LIM = -MANT_W;
    localparam logic signed [EXP_W:0] E_ONE = (EXP_W+1)'(1);

    state_t                  state;
    logic signed [EXP_W:0]   e;
    logic [MANT_W-1:0]       m;
    logic                    st;
    logic                    sign;
    logic                    nan_q;
    logic                    inf_q;
    logic                    zero_q;
    logic [SIG_W-1:0]        sig_r;
    logic                    tiny;
    logic                    inx;

    logic [SIG_W-1:0]        s;
    logic                    g;
    logic                    sticky_all;
    logic [SIG_W:0]          r;
    logic                    rnd_inexact;

    assign s          = m[HID -: SIG_W];
    assign g          = m[GRD];
    assign sticky_all = (|m[GRD-1:0]) | st;

    fp32_rne_round u_round (
        .s       (s),
        .g       (g),
        .S       (sticky_all),
        .r       (r),
        .inexact (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            e           <= '0;
            m           <= '0;
            st          <= 1'b0;
            sign        <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            sig_r       <= '0;
            tiny        <= 1'b0;
            inx         <= 1'b0;
            product_o   <= '0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sign   <= sign_i;
                        e      <= {exp_i[EXP_W-1], exp_i};
                        m      <= mant_i;
                        st     <= 1'b0;
                        nan_q  <= nan_i;
                        inf_q  <= inf_i;
                        zero_q <= zero_i;
                        busy_o <= 1'b1;
                        state  <= (nan_i | inf_i | zero_i) ? PACK : NORM;
                    end
                end
                NORM: begin
                    if (m[MANT_W-1]) begin
                        m     <= m >> 1;
                        st    <= st | m[0];
                        e     <= e + E_ONE;
                        state <= DENORM;
                    end else if (!m[HID] && (m != '0) && (int'(e) > 1)) begin
                        m <= m << 1;
                        e <= e - E_ONE;
                    end else begin
                        state <= DENORM;
                    end
                end
                DENORM: begin
`ifdef FP32_FTZ_EN
                    // Anything that would land below the normal range is flushed in one step.
                    if (((int'(e) < 1) || !m[HID]) && ((m != '0) || st)) begin
                        m     <= '0;
                        st    <= 1'b1;
                        e     <= E_ONE;
                        state <= ROUND;
                    end else if (int'(e) < 1) begin
                        e     <= E_ONE;
                        state <= ROUND;
                    end else begin
                        state <= ROUND;
                    end
`else
                    // Past 48 shifts every bit is sticky, so stop shifting early.
                    if (int'(e) <= DEN_LIM) begin
                        st    <= st | (|m);
                        m     <= '0;
                        e     <= E_ONE;
                        state <= ROUND;
                    end else if (int'(e) < 1) begin
                        m  <= m >> 1;
                        st <= st | m[0];
                        e  <= e + E_ONE;
                    end else begin
                        state <= ROUND;
                    end
`endif
                end
                ROUND: begin
                    tiny <= ~m[HID];
                    inx  <= rnd_inexact;
                    if (r[SIG_W]) begin
                        sig_r <= r[SIG_W:1];
                        e     <= e + E_ONE;
                    end else begin
                        sig_r <= r[SIG_W-1:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    overflow_o  <= 1'b0;
                    underflow_o <= 1'b0;
                    inexact_o   <= 1'b0;
                    if (nan_q) begin
                        product_o <= QNAN;
                    end else if (inf_q) begin
                        product_o <= {sign, 8'hFF, 23'h0};
                    end else if (zero_q || ((m == '0) && !st)) begin
                        product_o <= {sign, 31'h0};
                    end else if (int'(e) >= EXP_MAX) begin
                        product_o  <= {sign, 8'hFF, 23'h0};
                        overflow_o <= 1'b1;
                        inexact_o  <= 1'b1;
                    end else begin
                        // A subnormal that rounded up into bit 23 picks up field 1 from e.
                        product_o   <= {sign, (sig_r[SIG_W-1] ? e[7:0] : 8'h00), sig_r[FRAC_W-1:0]};
                        underflow_o <= tiny & inx;
                        inexact_o   <= inx;
                    end
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_round_pack.sv
// tb/tb_fp32_round_pack.sv - directed self-checking bench for fp32_round_pack
module tb_fp32_round_pack;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        sign_i;
    logic [9:0]  exp_i;
    logic [47:0] mant_i;
    logic        nan_i;
    logic        inf_i;
    logic        zero_i;
    logic [31:0] product_o;
    logic        done_o;
    logic        busy_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        inexact_o;

    int checks   = 0;
    int failures = 0;

    fp32_round_pack dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .sign_i      (sign_i),
        .exp_i       (exp_i),
        .mant_i      (mant_i),
        .nan_i       (nan_i),
        .inf_i       (inf_i),
        .zero_i      (zero_i),
        .product_o   (product_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .inexact_o   (inexact_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand set and waits (bounded) for done_o; lat is -1 on timeout.
    task automatic issue(input logic sg, input logic [9:0] ex, input logic [47:0] mn,
                         input logic n, input logic i, input logic z,
                         output int lat, output logic [31:0] prod, output logic [2:0] fl);
        sign_i = sg; exp_i = ex; mant_i = mn; nan_i = n; inf_i = i; zero_i = z;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1; prod = '0; fl = '0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (done_o) begin
                lat  = k;
                prod = product_o;
                fl   = {overflow_o, underflow_o, inexact_o};
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_i = 1'b0; sign_i = 1'b0; exp_i = '0; mant_i = '0;
        nan_i = 1'b0; inf_i = 1'b0; zero_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({product_o, done_o, busy_o, overflow_o, underflow_o, inexact_o} !== 37'h0) begin
            failures++;
            $display("FAIL reset_outputs got prod=%h done=%b busy=%b flags=%b%b%b required all 0",
                     product_o, done_o, busy_o, overflow_o, underflow_o, inexact_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_normal;
        int lat; logic [31:0] p; logic [2:0] f;
        issue(1'b0, 10'd127, 48'h900000000000, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== 32'h40100000) begin failures++; $display("FAIL normal_product got=%h required=40100000", p); end
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL normal_latency got=%0d required=4", lat); end
        checks++;
        if (f !== 3'b000) begin failures++; $display("FAIL normal_flags got=%b required=000", f); end
        @(posedge clk); #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL done_single_pulse got done=%b busy=%b required 0 0", done_o, busy_o);
        end
        checks++;
        if (product_o !== 32'h40100000) begin failures++; $display("FAIL product_hold got=%h required=40100000", product_o); end
    endtask

    task automatic test_left_norm;
        int lat; logic [31:0] p; logic [2:0] f;
        issue(1'b0, 10'd127, 48'h200000000000, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== 32'h3F000000 || f !== 3'b000) begin
            failures++; $display("FAIL left_norm got=%h flags=%b required=3F000000 flags=000", p, f);
        end
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL left_norm_latency got=%0d required=5", lat); end
    endtask

    task automatic test_overflow;
        int lat; logic [31:0] p; logic [2:0] f;
        issue(1'b0, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== 32'h7F800000 || f !== 3'b101) begin
            failures++; $display("FAIL overflow got=%h flags=%b required=7F800000 flags=101", p, f);
        end
    endtask

    task automatic test_rne;
        int lat; logic [31:0] p; logic [2:0] f;
        issue(1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== 32'h3F800000 || f !== 3'b001) begin
            failures++; $display("FAIL rne_tie_even got=%h flags=%b required=3F800000 flags=001", p, f);
        end
        issue(1'b0, 10'd127, 48'h400000C00000, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== 32'h3F800002 || f !== 3'b001) begin
            failures++; $display("FAIL rne_tie_odd got=%h flags=%b required=3F800002 flags=001", p, f);
        end
        issue(1'b1, 10'd127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== 32'hC0000000 || f !== 3'b001) begin
            failures++; $display("FAIL rne_carry got=%h flags=%b required=C0000000 flags=001", p, f);
        end
    endtask

    task automatic test_subnormal;
        int lat; logic [31:0] p; logic [2:0] f;
        logic [31:0] ep; logic [2:0] ef; int el;
`ifdef FP32_FTZ_EN
        ep = 32'h00000000; ef = 3'b011; el = 4;
`else
        ep = 32'h00100000; ef = 3'b000; el = 7;
`endif
        issue(1'b0, 10'h3FE, 48'h400000000000, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== ep || f !== ef) begin
            failures++; $display("FAIL subnormal got=%h flags=%b required=%h flags=%b", p, f, ep, ef);
        end
        checks++;
        if (lat !== el) begin failures++; $display("FAIL subnormal_latency got=%0d required=%0d", lat, el); end
`ifdef FP32_FTZ_EN
        ep = 32'h00000000; ef = 3'b011; el = 4;
`else
        ep = 32'h00400000; ef = 3'b011; el = 5;
`endif
        issue(1'b0, 10'd0, 48'h400000000001, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== ep || f !== ef || lat !== el) begin
            failures++; $display("FAIL subnormal_sticky got=%h flags=%b lat=%0d required=%h flags=%b lat=%0d",
                                 p, f, lat, ep, ef, el);
        end
        issue(1'b1, 10'h39C, 48'h400000000000, 1'b0, 1'b0, 1'b0, lat, p, f);
        checks++;
        if (p !== 32'h80000000 || f !== 3'b011 || lat !== 4) begin
            failures++; $display("FAIL deep_underflow got=%h flags=%b lat=%0d required=80000000 flags=011 lat=4",
                                 p, f, lat);
        end
    endtask

    task automatic test_specials;
        int lat; logic [31:0] p; logic [2:0] f;
        issue(1'b1, 10'd127, 48'h900000000000, 1'b1, 1'b1, 1'b0, lat, p, f);
        checks++;
        if (p !== 32'h7FC00000 || f !== 3'b000) begin
            failures++; $display("FAIL special_nan got=%h flags=%b required=7FC00000 flags=000", p, f);
        end
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL special_latency got=%0d required=1", lat); end
        issue(1'b1, 10'd127, 48'h900000000000, 1'b0, 1'b1, 1'b1, lat, p, f);
        checks++;
        if (p !== 32'hFF800000 || f !== 3'b000) begin
            failures++; $display("FAIL special_inf got=%h flags=%b required=FF800000 flags=000", p, f);
        end
        issue(1'b1, 10'd127, 48'h900000000000, 1'b0, 1'b0, 1'b1, lat, p, f);
        checks++;
        if (p !== 32'h80000000 || f !== 3'b000) begin
            failures++; $display("FAIL special_zero got=%h flags=%b required=80000000 flags=000", p, f);
        end
    endtask

    task automatic test_busy_ignore;
        int lat; int dones;
        sign_i = 1'b0; exp_i = 10'd127; mant_i = 48'h900000000000;
        nan_i = 1'b0; inf_i = 1'b0; zero_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        nan_i = 1'b1; exp_i = 10'd3; mant_i = 48'h1;
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_high got=%b required=1", busy_o); end
        start_i = 1'b0; nan_i = 1'b0;
        lat = -1;
        for (int k = 2; k <= 50; k++) begin
            @(posedge clk); #1;
            if (done_o) begin lat = k; break; end
        end
        checks++;
        if (lat !== 4 || product_o !== 32'h40100000) begin
            failures++; $display("FAIL busy_ignore got=%h lat=%0d required=40100000 lat=4", product_o, lat);
        end
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_o) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL busy_no_second got=%0d dones required=0", dones); end
    endtask

    task automatic test_reset_abort;
        int dones;
        sign_i = 1'b0; exp_i = 10'd127; mant_i = 48'h000000800000;
        nan_i = 1'b0; inf_i = 1'b0; zero_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b required=1", busy_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({product_o, done_o, busy_o, overflow_o, underflow_o, inexact_o} !== 37'h0) begin
            failures++;
            $display("FAIL abort_outputs got prod=%h done=%b busy=%b flags=%b%b%b required all 0",
                     product_o, done_o, busy_o, overflow_o, underflow_o, inexact_o);
        end
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o || busy_o) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL abort_no_done got=%0d active cycles required=0", dones); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_left_norm();
        test_overflow();
        test_rne();
        test_subnormal();
        test_specials();
        test_busy_ignore();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
